// File: rtl/queue_calc_ctrl.sv
// queue_calc_ctrl
// ---------------------------------------------------------------------------
// Token-driven controller placed directly upstream of the operand queue of
// the queue calculator. Each accepted token is decoded against a mirrored
// copy of the queue occupancy. Operand and operator results are turned into
// a single queue command (opcode + back byte). Overflow, underflow, illegal
// operators and divide-by-zero raise a sticky error. Only CLR or reset
// clears that error.
//
// Optional feature macro: QCALC_DIV_EN
//   defined     : operator 0xA = DIV (a/b), 0xB = MOD (a%b), binary, b==0 faults
//   not defined : 0xA/0xB are illegal and no divider is built
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   tok_valid    token present
//   tok_ready    controller can take a token (combinational from state)
//   tok_is_op    1 = operator token, 0 = operand token
//   tok_data     operand byte, or operator code in [3:0]
//   top_conc     queue front pair, a = [15:8] (front), b = [7:0]
//   q_valid      queue command strobe (one cycle, ISSUE state)
//   q_opcode     00 push, 01 replace front, 10 pop pair + push, 11 pop front
//   q_back       byte written by the queue command
//   depth        mirrored queue occupancy
//   res_valid    one-cycle pulse with each computed result
//   res_data     last computed result
//   err          sticky error flag
//   err_code     01 underflow, 10 overflow, 11 illegal op / divide by zero
//   o_dbg_state  current FSM state (IDLE=0, ISSUE=1, ERROR=2)
//
// Handshake: a token transfers on a rising edge where tok_valid && tok_ready.
// tok_valid may drop without a transfer, and no token is held internally.
module queue_calc_ctrl #(
    parameter int QDEPTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic        tok_is_op,
    input  logic [7:0]  tok_data,
    input  logic [15:0] top_conc,
    output logic        q_valid,
    output logic [1:0]  q_opcode,
    output logic [7:0]  q_back,
    output logic [2:0]  depth,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [2:0] QD3 = 3'(QDEPTH);

    state_t      r_state;
    logic [2:0]  r_depth_nxt;

    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [3:0]  w_code;
    logic [15:0] w_mul;
    logic [7:0]  w_alu;
    logic        w_fault;
    logic [1:0]  w_fcode;
    logic        w_cmd;
    logic [1:0]  w_opc;
    logic [7:0]  w_back;
    logic        w_res;
    logic [2:0]  w_dnext;

    assign w_a    = top_conc[15:8];
    assign w_b    = top_conc[7:0];
    assign w_code = tok_data[3:0];
    assign w_mul  = w_a * w_b;

    assign tok_ready   = rst && (r_state != ISSUE);
    assign o_dbg_state = r_state;

    always_comb begin
        w_alu = 8'h00;
        case (w_code)
            4'h0:    w_alu = w_a + w_b;
            4'h1:    w_alu = w_a - w_b;
            4'h2:    w_alu = w_mul[7:0];
            4'h3:    w_alu = w_a & w_b;
            4'h4:    w_alu = w_a | w_b;
            4'h5:    w_alu = w_a ^ w_b;
            4'h6:    w_alu = 8'h00 - w_a;
            4'h7:    w_alu = ~w_a;
`ifdef QCALC_DIV_EN
            // b == 0 is trapped as a fault below; the guard only keeps the
            // divider output defined.
            4'hA:    w_alu = (w_b == 8'h00) ? 8'h00 : (w_a / w_b);
            4'hB:    w_alu = (w_b == 8'h00) ? 8'h00 : (w_a % w_b);
`endif
            default: w_alu = 8'h00;
        endcase
    end

    // Token decode and occupancy check for the token currently offered.
    always_comb begin
        w_fault = 1'b0;
        w_fcode = 2'b00;
        w_cmd   = 1'b0;
        w_opc   = 2'b00;
        w_back  = 8'h00;
        w_res   = 1'b0;
        w_dnext = depth;
        if (!tok_is_op) begin
            if (depth >= QD3) begin
                w_fault = 1'b1;
                w_fcode = 2'b10;
            end else begin
                w_cmd   = 1'b1;
                w_opc   = 2'b00;
                w_back  = tok_data;
                w_dnext = depth + 3'd1;
            end
        end else begin
            case (w_code)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                    if (depth < 3'd2) begin
                        w_fault = 1'b1;
                        w_fcode = 2'b01;
                    end else begin
                        w_cmd   = 1'b1;
                        w_opc   = 2'b10;
                        w_back  = w_alu;
                        w_res   = 1'b1;
                        w_dnext = depth - 3'd1;
                    end
                end
                4'h6, 4'h7: begin
                    if (depth == 3'd0) begin
                        w_fault = 1'b1;
                        w_fcode = 2'b01;
                    end else begin
                        w_cmd  = 1'b1;
                        w_opc  = 2'b01;
                        w_back = w_alu;
                        w_res  = 1'b1;
                    end
                end
                4'h8: begin
                    if (depth == 3'd0) begin
                        w_fault = 1'b1;
                        w_fcode = 2'b01;
                    end else begin
                        w_cmd   = 1'b1;
                        w_opc   = 2'b11;
                        w_dnext = depth - 3'd1;
                    end
                end
                // CLR outside ERROR is consumed without a command.
                4'h9: ;
`ifdef QCALC_DIV_EN
                4'hA, 4'hB: begin
                    if (depth < 3'd2) begin
                        w_fault = 1'b1;
                        w_fcode = 2'b01;
                    end else if (w_b == 8'h00) begin
                        w_fault = 1'b1;
                        w_fcode = 2'b11;
                    end else begin
                        w_cmd   = 1'b1;
                        w_opc   = 2'b10;
                        w_back  = w_alu;
                        w_res   = 1'b1;
                        w_dnext = depth - 3'd1;
                    end
                end
`endif
                default: begin
                    w_fault = 1'b1;
                    w_fcode = 2'b11;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_depth_nxt <= 3'd0;
            q_valid     <= 1'b0;
            q_opcode    <= 2'b00;
            q_back      <= 8'h00;
            depth       <= 3'd0;
            res_valid   <= 1'b0;
            res_data    <= 8'h00;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            q_valid   <= 1'b0;
            res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tok_valid) begin
                        if (w_fault) begin
                            err      <= 1'b1;
                            err_code <= w_fcode;
                            r_state  <= ERROR;
                        end else if (w_cmd) begin
                            // Command and result are registered here so they
                            // are visible throughout the ISSUE cycle.
                            q_valid     <= 1'b1;
                            q_opcode    <= w_opc;
                            q_back      <= w_back;
                            r_depth_nxt <= w_dnext;
                            res_valid   <= w_res;
                            if (w_res) begin
                                res_data <= w_back;
                            end
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The queue applies the command at this edge; mirror it.
                    depth   <= r_depth_nxt;
                    r_state <= IDLE;
                end
                ERROR: begin
                    if (tok_valid && tok_is_op && (w_code == 4'h9)) begin
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_calc_ctrl.sv
module tb_queue_calc_ctrl;

  logic        clk;
  logic        rst;
  logic        tok_valid;
  logic        tok_ready;
  logic        tok_is_op;
  logic [7:0]  tok_data;
  logic [15:0] top_conc;
  logic        q_valid;
  logic [1:0]  q_opcode;
  logic [7:0]  q_back;
  logic [2:0]  depth;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  o_dbg_state;

  int n_total;
  int n_bad;

  // values captured by send(): ISSUE-cycle outputs, then settled status
  logic       c_qv;
  logic [1:0] c_opc;
  logic [7:0] c_back;
  logic       c_rv;
  logic [7:0] c_rd;
  logic [2:0] c_depth;
  logic       c_err;
  logic [1:0] c_code;

  queue_calc_ctrl #(.QDEPTH(5)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data),
    .top_conc(top_conc),
    .q_valid(q_valid), .q_opcode(q_opcode), .q_back(q_back),
    .depth(depth),
    .res_valid(res_valid), .res_data(res_data),
    .err(err), .err_code(err_code),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream queue model: supplies top_conc from applied commands
  logic [7:0] qm [0:7];
  int qn;

  always @(posedge clk) begin
    if (!rst) begin
      qn <= 0;
    end else if (q_valid) begin
      case (q_opcode)
        2'b00: begin qm[qn] <= q_back; qn <= qn + 1; end
        2'b01: qm[0] <= q_back;
        2'b10: begin
          for (int i = 0; i < 6; i++) qm[i] <= qm[i+2];
          qm[qn-2] <= q_back;
          qn <= qn - 1;
        end
        default: begin
          for (int i = 0; i < 7; i++) qm[i] <= qm[i+1];
          qn <= qn - 1;
        end
      endcase
    end
  end

  always_comb begin
    top_conc[15:8] = (qn > 0) ? qm[0] : 8'h00;
    top_conc[7:0]  = (qn > 1) ? qm[1] : 8'h00;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: offer one token at a negedge, wait (bounded) for acceptance,
  // capture the ISSUE-cycle outputs, then the settled status one cycle later
  task automatic send(input logic op, input logic [7:0] d);
    int k;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = op;
    tok_data  = d;
    k = 0;
    while (!tok_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept", {15'd0, tok_ready}, 16'd1);
    @(negedge clk);
    tok_valid = 1'b0;
    c_qv   = q_valid;
    c_opc  = q_opcode;
    c_back = q_back;
    c_rv   = res_valid;
    c_rd   = res_data;
    @(negedge clk);
    c_depth = depth;
    c_err   = err;
    c_code  = err_code;
  endtask

  task automatic expect_all(input string t, input logic qv, input logic [1:0] opc,
                            input logic [7:0] back, input logic rv, input logic [7:0] rd,
                            input logic [2:0] dep, input logic er, input logic [1:0] code);
    chk({t, ".q_valid"}, {15'd0, c_qv}, {15'd0, qv});
    if (qv) begin
      chk({t, ".q_opcode"}, {14'd0, c_opc}, {14'd0, opc});
      chk({t, ".q_back"}, {8'd0, c_back}, {8'd0, back});
    end
    chk({t, ".res_valid"}, {15'd0, c_rv}, {15'd0, rv});
    if (rv) chk({t, ".res_data"}, {8'd0, c_rd}, {8'd0, rd});
    chk({t, ".depth"}, {13'd0, c_depth}, {13'd0, dep});
    chk({t, ".err"}, {15'd0, c_err}, {15'd0, er});
    chk({t, ".err_code"}, {14'd0, c_code}, {14'd0, code});
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, ".q_valid"}, {15'd0, q_valid}, 16'd0);
    chk({t, ".q_opcode"}, {14'd0, q_opcode}, 16'd0);
    chk({t, ".q_back"}, {8'd0, q_back}, 16'd0);
    chk({t, ".depth"}, {13'd0, depth}, 16'd0);
    chk({t, ".res_valid"}, {15'd0, res_valid}, 16'd0);
    chk({t, ".res_data"}, {8'd0, res_data}, 16'd0);
    chk({t, ".err"}, {15'd0, err}, 16'd0);
    chk({t, ".err_code"}, {14'd0, err_code}, 16'd0);
    chk({t, ".tok_ready"}, {15'd0, tok_ready}, 16'd0);
    chk({t, ".state"}, {14'd0, o_dbg_state}, 16'd0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {15'd0, tok_ready}, 16'd1);

    // 3, 5, ADD
    send(1'b0, 8'h03); expect_all("push3", 1, 2'b00, 8'h03, 0, 8'h00, 3'd1, 0, 2'b00);
    send(1'b0, 8'h05); expect_all("push5", 1, 2'b00, 8'h05, 0, 8'h00, 3'd2, 0, 2'b00);
    send(1'b1, 8'h00); expect_all("add",   1, 2'b10, 8'h08, 1, 8'h08, 3'd1, 0, 2'b00);

    // SUB at depth 1 -> underflow; tokens discarded in ERROR; CLR
    send(1'b1, 8'h01); expect_all("sub_uf",  0, 2'b00, 8'h00, 0, 8'h00, 3'd1, 1, 2'b01);
    send(1'b0, 8'h44); expect_all("err_tok", 0, 2'b00, 8'h00, 0, 8'h00, 3'd1, 1, 2'b01);
    send(1'b1, 8'h09); expect_all("clr1",    0, 2'b00, 8'h00, 0, 8'h00, 3'd1, 0, 2'b00);

    // DROP, then DROP at depth 0 -> underflow
    send(1'b1, 8'h08); expect_all("drop",    1, 2'b11, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);
    send(1'b1, 8'h08); expect_all("drop_uf", 0, 2'b00, 8'h00, 0, 8'h00, 3'd0, 1, 2'b01);
    send(1'b1, 8'h09); expect_all("clr2",    0, 2'b00, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);

    // 2 - 5 wraps
    send(1'b0, 8'h02); expect_all("push2", 1, 2'b00, 8'h02, 0, 8'h00, 3'd1, 0, 2'b00);
    send(1'b0, 8'h05); expect_all("push5b", 1, 2'b00, 8'h05, 0, 8'h00, 3'd2, 0, 2'b00);
    send(1'b1, 8'h01); expect_all("sub_wrap", 1, 2'b10, 8'hFD, 1, 8'hFD, 3'd1, 0, 2'b00);
    send(1'b1, 8'h08); expect_all("drop2", 1, 2'b11, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);

    // 0x10 * 0x20 low byte; upper nibble of operator code ignored
    send(1'b0, 8'h10); expect_all("push10", 1, 2'b00, 8'h10, 0, 8'h00, 3'd1, 0, 2'b00);
    send(1'b0, 8'h20); expect_all("push20", 1, 2'b00, 8'h20, 0, 8'h00, 3'd2, 0, 2'b00);
    send(1'b1, 8'h52); expect_all("mul", 1, 2'b10, 8'h00, 1, 8'h00, 3'd1, 0, 2'b00);
    send(1'b1, 8'h08); expect_all("drop3", 1, 2'b11, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);

    // unary NOT and NEG
    send(1'b0, 8'h0F); expect_all("push0f", 1, 2'b00, 8'h0F, 0, 8'h00, 3'd1, 0, 2'b00);
    send(1'b1, 8'h07); expect_all("not", 1, 2'b01, 8'hF0, 1, 8'hF0, 3'd1, 0, 2'b00);
    send(1'b1, 8'h06); expect_all("neg", 1, 2'b01, 8'h10, 1, 8'h10, 3'd1, 0, 2'b00);
    send(1'b1, 8'h08); expect_all("drop4", 1, 2'b11, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);

    // CLR in IDLE is a no-op
    send(1'b1, 8'h09); expect_all("clr_idle", 0, 2'b00, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);

    // fill to 5, sixth overflows, CLR keeps depth
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 8'(i));
      expect_all("fill", 1, 2'b00, 8'(i), 0, 8'h00, 3'(i), 0, 2'b00);
    end
    send(1'b0, 8'h66); expect_all("overflow", 0, 2'b00, 8'h00, 0, 8'h00, 3'd5, 1, 2'b10);
    send(1'b1, 8'h09); expect_all("clr3", 0, 2'b00, 8'h00, 0, 8'h00, 3'd5, 0, 2'b00);

    // illegal operator
    send(1'b1, 8'h0C); expect_all("illegal_c", 0, 2'b00, 8'h00, 0, 8'h00, 3'd5, 1, 2'b11);
    send(1'b1, 8'h09); expect_all("clr4", 0, 2'b00, 8'h00, 0, 8'h00, 3'd5, 0, 2'b00);

    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'h08);
      expect_all("drain", 1, 2'b11, 8'h00, 0, 8'h00, 3'(4 - i), 0, 2'b00);
    end

`ifdef QCALC_DIV_EN
    send(1'b0, 8'h07); send(1'b0, 8'h02);
    send(1'b1, 8'h0A); expect_all("div", 1, 2'b10, 8'h03, 1, 8'h03, 3'd1, 0, 2'b00);
    send(1'b1, 8'h08);
    send(1'b0, 8'h07); send(1'b0, 8'h02);
    send(1'b1, 8'h0B); expect_all("mod", 1, 2'b10, 8'h01, 1, 8'h01, 3'd1, 0, 2'b00);
    send(1'b1, 8'h08);
    send(1'b0, 8'h07); send(1'b0, 8'h00);
    send(1'b1, 8'h0A); expect_all("div0", 0, 2'b00, 8'h00, 0, 8'h00, 3'd2, 1, 2'b11);
    send(1'b1, 8'h09);
    send(1'b1, 8'h08); send(1'b1, 8'h08);
    expect_all("div_drain", 1, 2'b11, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);
`else
    send(1'b1, 8'h0A); expect_all("div_off", 0, 2'b00, 8'h00, 0, 8'h00, 3'd0, 1, 2'b11);
    send(1'b1, 8'h09); expect_all("clr5", 0, 2'b00, 8'h00, 0, 8'h00, 3'd0, 0, 2'b00);
`endif

    // reset asserted during ISSUE
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = 1'b0;
    tok_data  = 8'h09;
    @(negedge clk);
    tok_valid = 1'b0;
    chk("mid.q_valid_issue", {15'd0, q_valid}, 16'd1);
    rst = 1'b0;
    chk("mid.ready_in_reset", {15'd0, tok_ready}, 16'd0);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    chk("mid.ready_held", {15'd0, tok_ready}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid.ready_release", {15'd0, tok_ready}, 16'd1);
    send(1'b0, 8'h21); expect_all("post_reset_push", 1, 2'b00, 8'h21, 0, 8'h00, 3'd1, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
